simd_top_pl: RTL and testbench

- Top-level programmable-logic core of a small SIMD matrix processor.
- Fetches 32-bit instructions from an external instruction memory over a PC/instruction port.
- Loads two 2x2 integer matrices A and B from a 32-bit BRAM (port B), computes C = A x B with multiply-accumulate, stores C back to BRAM and signals completion on a GPIO.

---
 rtl/simd_top_pl.sv | 191 +++++++++++++++++++
 tb/tb_simd_top_pl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_top_pl.sv
// simd_top_pl: programmable-logic core of a small SIMD matrix processor.
// Fetches instructions over a PC/instruction port, loads 2x2 matrices A and B
// from BRAM, computes C = A x B with wrapping 32-bit multiply-accumulate,
// writes C back to BRAM and raises STOP_SIGNAL when a STOP instruction runs.
// RSTN is an active-high asynchronous reset despite its name.
module simd_top_pl #(
    parameter int N = 512
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 START_SIGNAL,
    output logic                 STOP_SIGNAL,
    output logic [$clog2(N)-1:0] PC_AXI,
    input  logic [31:0]          INSTR_AXI,
    output logic [12:0]          addrb,
    output logic [31:0]          dinb,
    input  logic [31:0]          doutb,
    output logic                 enb,
    output logic [3:0]           web
);

    localparam int PW = $clog2(N);

    localparam logic [2:0] OP_LOADA   = 3'd2;
    localparam logic [2:0] OP_LOADB   = 3'd3;
    localparam logic [2:0] OP_MULTACC = 3'd4;
    localparam logic [2:0] OP_STORE   = 3'd5;
    localparam logic [2:0] OP_STOP    = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_t;

    state_t      state;
    logic [1:0]  step;
    logic [1:0]  last_step;
    logic [2:0]  op;
    logic [5:0]  base;
    logic        load_row;
    logic        row_ptr_a;
    logic        row_ptr_b;

    logic [31:0] a [2][2];
    logic [31:0] b [2][2];
    logic [31:0] c [2][2];

    logic [2:0]  dec_op;
    logic [5:0]  dec_base;
    logic        dec_first;
    logic        unused_instr_bits;
    logic [PW-1:0] pc_next;
    logic [1:0]  store_next;

    assign dec_op            = INSTR_AXI[2:0];
    assign dec_base          = INSTR_AXI[12:7];
    assign dec_first         = INSTR_AXI[13];
    assign unused_instr_bits = ^{INSTR_AXI[31:14], INSTR_AXI[6:3]};
    assign pc_next           = (PC_AXI == PW'(N - 1)) ? '0 : PC_AXI + PW'(1);
    assign store_next        = step + 2'd1;

    // Byte address of word (base + off); BRAM addresses are word index x 4.
    function automatic logic [12:0] byte_addr(input logic [5:0] wbase, input logic [1:0] off);
        logic [6:0] word;
        word = {1'b0, wbase} + {5'b0, off};
        return {4'b0, word, 2'b00};
    endfunction

    // Instruction sequencer: fetch, decode, then a fixed number of execute
    // steps per opcode; all BRAM outputs are registered one cycle ahead of use.
    always_ff @(posedge CLK or posedge RSTN) begin
        if (RSTN) begin
            state       <= ST_IDLE;
            PC_AXI      <= '0;
            STOP_SIGNAL <= 1'b0;
            enb         <= 1'b0;
            web         <= 4'h0;
            addrb       <= '0;
            dinb        <= '0;
            step        <= '0;
            last_step   <= '0;
            op          <= '0;
            base        <= '0;
            load_row    <= 1'b0;
            row_ptr_a   <= 1'b0;
            row_ptr_b   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    a[i][j] <= '0;
                    b[i][j] <= '0;
                    c[i][j] <= '0;
                end
            end
        end else begin
            enb <= 1'b0;
            web <= 4'h0;
            case (state)
                ST_IDLE: begin
                    if (START_SIGNAL) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    op   <= dec_op;
                    base <= dec_base;
                    step <= 2'd0;
                    case (dec_op)
                        OP_LOADA, OP_LOADB: begin
                            enb       <= 1'b1;
                            addrb     <= byte_addr(dec_base, 2'd0);
                            last_step <= 2'd2;
                            state     <= ST_EXEC;
                            if (dec_op == OP_LOADA) begin
                                load_row  <= dec_first ? 1'b0 : row_ptr_a;
                                row_ptr_a <= dec_first ? 1'b1 : ~row_ptr_a;
                            end else begin
                                load_row  <= dec_first ? 1'b0 : row_ptr_b;
                                row_ptr_b <= dec_first ? 1'b1 : ~row_ptr_b;
                            end
                        end
                        OP_MULTACC: begin
                            last_step <= 2'd2;
                            state     <= ST_EXEC;
                        end
                        OP_STORE: begin
                            enb       <= 1'b1;
                            web       <= 4'hF;
                            addrb     <= byte_addr(dec_base, 2'd0);
                            dinb      <= c[0][0];
                            last_step <= 2'd3;
                            state     <= ST_EXEC;
                        end
                        OP_STOP: begin
                            STOP_SIGNAL <= 1'b1;
                            state       <= ST_HALT;
                        end
                        default: begin
                            PC_AXI <= pc_next;
                            state  <= ST_FETCH;
                        end
                    endcase
                end
                ST_EXEC: begin
                    case (op)
                        OP_LOADA, OP_LOADB: begin
                            if (step == 2'd0) begin
                                enb   <= 1'b1;
                                addrb <= byte_addr(base, 2'd1);
                            end else if (op == OP_LOADA) begin
                                a[load_row][step[1]] <= doutb;
                            end else begin
                                b[load_row][step[1]] <= doutb;
                            end
                        end
                        OP_MULTACC: begin
                            if (step != 2'd2) begin
                                c[step[0]][0] <= a[step[0]][0] * b[0][0] + a[step[0]][1] * b[1][0];
                                c[step[0]][1] <= a[step[0]][0] * b[0][1] + a[step[0]][1] * b[1][1];
                            end
                        end
                        default: begin
                            if (step != 2'd3) begin
                                enb   <= 1'b1;
                                web   <= 4'hF;
                                addrb <= byte_addr(base, store_next);
                                dinb  <= c[store_next[1]][store_next[0]];
                            end
                        end
                    endcase
                    if (step == last_step) begin
                        PC_AXI <= pc_next;
                        state  <= ST_FETCH;
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simd_top_pl.sv
// tb_simd_top_pl: directed self-checking bench for simd_top_pl with a
// behavioural instruction memory and a 1-cycle-latency BRAM model.
module tb_simd_top_pl;

    logic        CLK;
    logic        RSTN;
    logic        START_SIGNAL;
    logic        STOP_SIGNAL;
    logic [8:0]  PC_AXI;
    logic [31:0] INSTR_AXI;
    logic [12:0] addrb;
    logic [31:0] dinb;
    logic [31:0] doutb;
    logic        enb;
    logic [3:0]  web;

    logic [31:0] imem [0:511];
    logic [31:0] bram [0:2047];

    int checks;
    int errors;
    int stop_cyc;
    int ev_cyc[$];
    int ev_addr[$];
    int ev_web[$];
    logic [31:0] ev_din[$];

    simd_top_pl #(.N(512)) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .START_SIGNAL (START_SIGNAL),
        .STOP_SIGNAL  (STOP_SIGNAL),
        .PC_AXI       (PC_AXI),
        .INSTR_AXI    (INSTR_AXI),
        .addrb        (addrb),
        .dinb         (dinb),
        .doutb        (doutb),
        .enb          (enb),
        .web          (web)
    );

    // 10 ns clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Instruction memory: word for PC_AXI appears the following cycle
    always @(posedge CLK) begin
        INSTR_AXI <= imem[PC_AXI];
    end

    // BRAM port B: read-before-write, 1-cycle read latency
    always @(posedge CLK) begin
        if (enb) begin
            doutb <= bram[addrb[12:2]];
            if (web == 4'hF) bram[addrb[12:2]] = dinb;
        end
    end

    function automatic logic [31:0] enc(input int opc, input int wbase, input int first);
        return 32'(opc) | (32'd1 << 5) | (32'(wbase) << 7) | (32'(first) << 13);
    endfunction

    task automatic apply_reset();
        @(negedge CLK);
        RSTN = 1'b1;
        START_SIGNAL = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b0;
    endtask

    // Raise START and log every BRAM access for ncyc cycles; cycle 1 is the first FETCH
    task automatic run_program(input int ncyc);
        ev_cyc.delete(); ev_addr.delete(); ev_web.delete(); ev_din.delete();
        stop_cyc = -1;
        START_SIGNAL = 1'b1;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (enb) begin
                ev_cyc.push_back(cyc);
                ev_addr.push_back(int'(addrb));
                ev_web.push_back(int'(web));
                ev_din.push_back(dinb);
            end
            if (STOP_SIGNAL && stop_cyc < 0) stop_cyc = cyc;
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RSTN = 1'b1;
        START_SIGNAL = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({STOP_SIGNAL, PC_AXI, enb, web, addrb, dinb} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: stop=%0b pc=%0d enb=%0b web=%h addrb=%0d dinb=%h, required all zero",
                     STOP_SIGNAL, PC_AXI, enb, web, addrb, dinb);
        end
        RSTN = 1'b0;
        repeat (5) @(negedge CLK);
        checks++;
        if (PC_AXI !== 9'd0 || enb !== 1'b0 || STOP_SIGNAL !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_hold: pc=%0d enb=%0b stop=%0b, required pc=0 enb=0 stop=0",
                     PC_AXI, enb, STOP_SIGNAL);
        end
    endtask

    task automatic test_matmul();
        int exp_cyc [12]  = '{3, 4, 8, 9, 13, 14, 18, 19, 28, 29, 30, 31};
        int exp_addr [12] = '{24, 28, 56, 60, 92, 96, 124, 128, 144, 148, 152, 156};
        logic [31:0] exp_c [4] = '{32'd4088, 32'd1952, 32'd3561, 32'd3117};
        int n;
        imem[0] = 32'h2322; imem[1] = 32'h0722;
        imem[2] = 32'h2BA3; imem[3] = 32'h0FA3;
        imem[4] = 32'h0004; imem[5] = 32'h1205; imem[6] = 32'h0006;
        bram[6] = 25; bram[7] = 29; bram[14] = 47; bram[15] = 12;
        bram[23] = 51; bram[24] = 63; bram[31] = 97; bram[32] = 13;
        for (int i = 36; i < 40; i++) bram[i] = 32'hDEADBEEF;
        run_program(40);
        checks++;
        if (ev_cyc.size() != 12) begin
            errors++;
            $display("[TB] FAIL matmul_access_count: got %0d, required 12", ev_cyc.size());
        end
        n = (ev_cyc.size() < 12) ? ev_cyc.size() : 12;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (ev_cyc[i] != exp_cyc[i] || ev_addr[i] != exp_addr[i] ||
                ev_web[i] != ((i >= 8) ? 15 : 0) ||
                (i >= 8 && ev_din[i] !== exp_c[i-8])) begin
                errors++;
                $display("[TB] FAIL matmul_access%0d: cyc=%0d addr=%0d web=%h din=%0d, required cyc=%0d addr=%0d web=%h din=%0d",
                         i, ev_cyc[i], ev_addr[i], ev_web[i], ev_din[i], exp_cyc[i], exp_addr[i],
                         (i >= 8) ? 15 : 0, (i >= 8) ? exp_c[i-8] : ev_din[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bram[36+i] !== exp_c[i]) begin
                errors++;
                $display("[TB] FAIL matmul_mem_c%0d: got %0d, required %0d", i, bram[36+i], exp_c[i]);
            end
        end
        checks++;
        if (stop_cyc != 34) begin
            errors++;
            $display("[TB] FAIL stop_timing: STOP_SIGNAL rose at cycle %0d, required 34", stop_cyc);
        end
    endtask

    task automatic test_halt_hold();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checks++;
            if (STOP_SIGNAL !== 1'b1 || enb !== 1'b0 || web !== 4'h0 || PC_AXI !== 9'd6) begin
                errors++;
                $display("[TB] FAIL halt_hold%0d: stop=%0b enb=%0b web=%h pc=%0d, required stop=1 enb=0 web=0 pc=6",
                         i, STOP_SIGNAL, enb, web, PC_AXI);
            end
        end
    endtask

    task automatic test_nop_zero_mult();
        apply_reset();
        checks++;
        if (PC_AXI !== 9'd0 || STOP_SIGNAL !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_from_halt: pc=%0d stop=%0b, required pc=0 stop=0", PC_AXI, STOP_SIGNAL);
        end
        imem[0] = 32'h0000; imem[1] = 32'h0007; imem[2] = 32'h0004;
        imem[3] = 32'h1E05; imem[4] = 32'h0006;
        for (int i = 60; i < 64; i++) bram[i] = 32'h55555555;
        run_program(24);
        checks++;
        if (ev_cyc.size() != 4 || ev_cyc[0] != 12 || ev_addr[0] != 240) begin
            errors++;
            $display("[TB] FAIL nop_timing: accesses=%0d first_cyc=%0d first_addr=%0d, required 4, 12, 240",
                     ev_cyc.size(), (ev_cyc.size() > 0) ? ev_cyc[0] : -1, (ev_addr.size() > 0) ? ev_addr[0] : -1);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bram[60+i] !== 32'd0) begin
                errors++;
                $display("[TB] FAIL zero_mult_c%0d: got %h, required 0", i, bram[60+i]);
            end
        end
        checks++;
        if (stop_cyc != 18 || PC_AXI !== 9'd4) begin
            errors++;
            $display("[TB] FAIL nop_stop: stop_cyc=%0d pc=%0d, required 18 and 4", stop_cyc, PC_AXI);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        imem[0] = enc(2, 40, 1); imem[1] = enc(2, 42, 0);
        imem[2] = enc(3, 44, 1); imem[3] = enc(3, 46, 0);
        imem[4] = 32'h0004; imem[5] = 32'h1905; imem[6] = 32'h0006;
        bram[40] = 32'hFFFFFFFF; bram[41] = 0; bram[42] = 0; bram[43] = 0;
        bram[44] = 2; bram[45] = 0; bram[46] = 0; bram[47] = 0;
        for (int i = 50; i < 54; i++) bram[i] = 32'hDEADBEEF;
        run_program(40);
        checks++;
        if (bram[50] !== 32'hFFFFFFFE) begin
            errors++;
            $display("[TB] FAIL overflow_c00: got %h, required fffffffe", bram[50]);
        end
        checks++;
        if ({bram[51], bram[52], bram[53]} !== 96'd0) begin
            errors++;
            $display("[TB] FAIL overflow_rest: got %h %h %h, required 0 0 0", bram[51], bram[52], bram[53]);
        end
        checks++;
        if (stop_cyc != 34) begin
            errors++;
            $display("[TB] FAIL overflow_stop: STOP_SIGNAL rose at cycle %0d, required 34", stop_cyc);
        end
    endtask

    // Test sequence
    initial begin
        checks = 0;
        errors = 0;
        RSTN = 1'b1;
        START_SIGNAL = 1'b0;
        for (int i = 0; i < 512; i++) imem[i] = 32'h0;
        for (int i = 0; i < 2048; i++) bram[i] = 32'h0;
        test_reset();
        test_matmul();
        test_halt_hold();
        test_nop_zero_mult();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
